// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared widths, channel indices and helpers for the perf counter bank
package perf_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int N_CNT_DEF = 7;

    localparam int CNT_CTRL  = 0;
    localparam int CNT_ALU   = 1;
    localparam int CNT_INST  = 2;
    localparam int CNT_CYCLE = 3;
    localparam int CNT_STALL = 4;
    localparam int CNT_LOAD  = 5;
    localparam int CNT_STORE = 6;

    // Read index width; a single-channel bank still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - read request/response bus of the perf counter bank
interface perf_counter_bank_if #(
    parameter int N_CNT = perf_pkg::N_CNT_DEF,
    parameter int CNT_W = perf_pkg::CNT_W_DEF
);
    localparam int IDX_W = perf_pkg::idx_width(N_CNT);

    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;

    modport master (output rd_en, output rd_idx, input rd_valid, input rd_data, input rd_ovf);
    modport slave  (input rd_en, input rd_idx, output rd_valid, output rd_data, output rd_ovf);

endinterface

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one event counter with clear/freeze, wrap or saturate, sticky overflow
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_freeze,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc && !i_freeze) begin
            if (&r_cnt) begin
                // At all-ones: flag the overflow, then either wrap or pin the value
                r_ovf <= 1'b1;
                if (SATURATE == 0) begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of N_CNT event counters with 1-cycle read port; PERF_SNAPSHOT_EN adds shadow snapshots
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int N_CNT    = N_CNT_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CNT-1:0]   inc,
    input  logic               freeze,
    input  logic               clr,
    input  logic               snap,
    output logic [N_CNT-1:0]   ovf,
    perf_counter_bank_if.slave rd_bus
);

    localparam int IDX_W = idx_width(N_CNT);

    logic [CNT_W-1:0] w_cnt [N_CNT];
    logic [CNT_W-1:0] w_src [N_CNT];
    logic [CNT_W-1:0] w_sel_data;
    logic             w_sel_ovf;

    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_ovf;

    for (genvar g = 0; g < N_CNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .i_inc    (inc[g]),
            .i_freeze (freeze),
            .i_clr    (clr),
            .o_cnt    (w_cnt[g]),
            .o_ovf    (ovf[g])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] r_shadow [N_CNT];

    // Captures pre-update values, so a same-cycle clr still leaves the old counts here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CNT; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (snap) begin
            r_shadow <= w_cnt;
        end
    end

    assign w_src = r_shadow;
`else
    logic w_unused_snap;

    assign w_unused_snap = snap;
    assign w_src         = w_cnt;
`endif

    // Indices with no matching channel fall through to zero data and a clear flag
    always_comb begin
        w_sel_data = '0;
        w_sel_ovf  = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            if (rd_bus.rd_idx == IDX_W'(i)) begin
                w_sel_data = w_src[i];
                w_sel_ovf  = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_rd_valid <= rd_bus.rd_en;
            if (rd_bus.rd_en) begin
                r_rd_data <= w_sel_data;
                r_rd_ovf  <= w_sel_ovf;
            end
        end
    end

    assign rd_bus.rd_valid = r_rd_valid;
    assign rd_bus.rd_data  = r_rd_data;
    assign rd_bus.rd_ovf   = r_rd_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench for perf_counter_bank (16-bit wrap, 8-bit wrap, 8-bit saturate)
module tb_perf_counter_bank;

    logic       clk;
    logic       reset;
    logic [6:0] inc;
    logic       freeze;
    logic       clr;
    logic       snap;
    logic       rd_en;
    logic [2:0] rd_idx;
    logic [6:0] ovf_m;
    logic [6:0] ovf_w;
    logic [6:0] ovf_s;

    int n_checks;
    int n_fail;

    perf_counter_bank_if #(.N_CNT(7), .CNT_W(16)) bus_m ();
    perf_counter_bank_if #(.N_CNT(7), .CNT_W(8))  bus_w ();
    perf_counter_bank_if #(.N_CNT(7), .CNT_W(8))  bus_s ();

    assign bus_m.rd_en  = rd_en;
    assign bus_m.rd_idx = rd_idx;
    assign bus_w.rd_en  = rd_en;
    assign bus_w.rd_idx = rd_idx;
    assign bus_s.rd_en  = rd_en;
    assign bus_s.rd_idx = rd_idx;

    perf_counter_bank #(.N_CNT(7), .CNT_W(16), .SATURATE(0)) u_dut_m (
        .clk(clk), .reset(reset), .inc(inc), .freeze(freeze), .clr(clr),
        .snap(snap), .ovf(ovf_m), .rd_bus(bus_m)
    );

    perf_counter_bank #(.N_CNT(7), .CNT_W(8), .SATURATE(0)) u_dut_w (
        .clk(clk), .reset(reset), .inc(inc), .freeze(freeze), .clr(clr),
        .snap(snap), .ovf(ovf_w), .rd_bus(bus_w)
    );

    perf_counter_bank #(.N_CNT(7), .CNT_W(8), .SATURATE(1)) u_dut_s (
        .clk(clk), .reset(reset), .inc(inc), .freeze(freeze), .clr(clr),
        .snap(snap), .ovf(ovf_s), .rd_bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_one(input logic [2:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        inc      = '0;
        freeze   = 1'b0;
        clr      = 1'b0;
        snap     = 1'b0;
        rd_en    = 1'b0;
        rd_idx   = '0;

        #12;
        chk("reset_rd_valid", 32'(bus_m.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus_m.rd_data),  32'd0);
        chk("reset_rd_ovf",   32'(bus_m.rd_ovf),   32'd0);
        chk("reset_ovf",      32'(ovf_m),          32'd0);
        reset = 1'b1;

        // Ten cycles of all-channel increments, then one read of channel 3
        inc = 7'h7F;
        repeat (10) tick();
        inc    = '0;
        rd_en  = 1'b1;
        rd_idx = 3'd3;
        chk("read_latency_pre", 32'(bus_m.rd_valid), 32'd0);
        tick();
        rd_en = 1'b0;
        chk("read_idx3_valid", 32'(bus_m.rd_valid), 32'd1);
        chk("read_idx3_data",  32'(bus_m.rd_data),  32'd10);
        chk("read_idx3_ovf",   32'(bus_m.rd_ovf),   32'd0);
        tick();
        chk("read_valid_drop", 32'(bus_m.rd_valid), 32'd0);
        chk("read_data_hold",  32'(bus_m.rd_data),  32'd10);

        // Back-to-back reads of a channel that counts every cycle: old value each time
        inc    = 7'b000_0100;
        rd_en  = 1'b1;
        rd_idx = 3'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b2b_valid", 32'(bus_m.rd_valid), 32'd1);
            chk("b2b_data",  32'(bus_m.rd_data),  32'(10 + k));
        end
        inc   = '0;
        rd_en = 1'b0;
        tick();
        read_one(3'd2);
        chk("b2b_final", 32'(bus_m.rd_data), 32'd13);

        // Freeze holds through active increments, counting resumes afterwards
        freeze = 1'b1;
        inc    = 7'h7F;
        repeat (4) tick();
        read_one(3'd0);
        chk("freeze_hold", 32'(bus_m.rd_data), 32'd10);
        freeze = 1'b0;
        tick();
        inc = '0;
        read_one(3'd0);
        chk("freeze_resume", 32'(bus_m.rd_data), 32'd11);

        // Clear wins over same-cycle increments
        clr = 1'b1;
        tick();
        clr = 1'b0;
        inc = 7'h7F;
        repeat (5) tick();
        inc = '0;
        read_one(3'd6);
        chk("pre_clr_five", 32'(bus_m.rd_data), 32'd5);
        clr = 1'b1;
        inc = 7'h7F;
        tick();
        clr = 1'b0;
        inc = '0;
        read_one(3'd4);
        chk("clr_data", 32'(bus_m.rd_data), 32'd0);
        chk("clr_ovf",  32'(ovf_m),         32'd0);

        // 257 pulses on channel 0: 8-bit wraps to 1, 8-bit saturates at 255
        inc = 7'b000_0001;
        repeat (257) tick();
        inc = '0;
        read_one(3'd0);
        chk("w16_data",   32'(bus_m.rd_data), 32'd257);
        chk("w16_ovf",    32'(ovf_m),         32'd0);
        chk("wrap8_data", 32'(bus_w.rd_data), 32'd1);
        chk("wrap8_ovf",  32'(ovf_w),         32'h01);
        chk("wrap8_rovf", 32'(bus_w.rd_ovf),  32'd1);
        chk("sat8_data",  32'(bus_s.rd_data), 32'd255);
        chk("sat8_ovf",   32'(ovf_s),         32'h01);

        // Index beyond the last channel reads as zero but is still valid
        read_one(3'd7);
        chk("oor_valid", 32'(bus_w.rd_valid), 32'd1);
        chk("oor_data",  32'(bus_w.rd_data),  32'd0);
        chk("oor_ovf",   32'(bus_w.rd_ovf),   32'd0);

        // Snapshot together with clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_sticky_ovf", 32'(ovf_w), 32'd0);
        inc = 7'b000_0001;
        repeat (20) tick();
        inc  = '0;
        snap = 1'b1;
        clr  = 1'b1;
        tick();
        snap = 1'b0;
        clr  = 1'b0;
        read_one(3'd0);
`ifdef PERF_SNAPSHOT_EN
        chk("snap_shadow", 32'(bus_m.rd_data), 32'd20);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_one(3'd0);
        chk("snap_live_zero", 32'(bus_m.rd_data), 32'd0);
`else
        chk("snap_ignored", 32'(bus_m.rd_data), 32'd0);
`endif

        // Asynchronous reset in the middle of counting with a read in flight
        inc    = 7'h7F;
        rd_en  = 1'b1;
        rd_idx = 3'd0;
        tick();
        chk("pre_reset_valid", 32'(bus_m.rd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_m.rd_valid), 32'd0);
        chk("async_rst_data",  32'(bus_m.rd_data),  32'd0);
        chk("async_rst_ovf",   32'(ovf_m),          32'd0);
        rd_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_no_valid", 32'(bus_m.rd_valid), 32'd0);
        inc = '0;
        read_one(3'd5);
        chk("post_rst_count", 32'(bus_m.rd_data), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter N_CNT, default 7, number of counter channels (1..16).
REQ-002 Parameter CNT_W, default 16, counter width in bits (8..32).
REQ-003 Parameter SATURATE, default 0, selects counter overflow behaviour: 0 = wrap-around, 1 = hold at all-ones.
REQ-004 Port clk, input, 1, single clock; all state is updated on the rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port inc, input, N_CNT, per-channel increment-by-one event (e.g. ctrl inst, ALU inst, cycle, stall, load, store).
REQ-007 Port freeze, input, 1, while high all counters hold.
REQ-008 Port clr, input, 1, synchronous clear of all counters and overflow flags.
REQ-009 Port snap, input, 1, captures all counters into shadow registers (PERF_SNAPSHOT_EN only).
REQ-010 Port rd_en, input, 1, read request.
REQ-011 Port rd_idx, input, $clog2(N_CNT) bits (minimum 1), channel to read.
REQ-012 Port rd_valid, output, 1, read data valid.
REQ-013 Port rd_data, output, CNT_W, counter (or shadow) value.
REQ-014 Port rd_ovf, output, 1, sticky overflow flag of the channel being read.
REQ-015 Port ovf, output, N_CNT, live sticky overflow flags.

Function
REQ-016 Per cycle, channel i increments by 1 when inc[i]=1, freeze=0 and clr=0.
REQ-017 With SATURATE=0, a counter at all-ones that increments wraps to 0 and sets ovf[i].
REQ-018 With SATURATE=1, a counter at all-ones holds all-ones, and an increment attempt sets ovf[i].
REQ-019 ovf[i] is sticky; only clr or reset clears it.
REQ-020 clr has priority over inc and freeze: counters and ovf become 0 on the next edge, and same-cycle increments are dropped.
REQ-021 freeze=1 with clr=0 holds counters and flags unchanged.
REQ-022 Read latency is one cycle: rd_en in cycle t gives rd_valid=1 with rd_data/rd_ovf in cycle t+1; otherwise rd_valid=0 and rd_data holds its last value.
REQ-023 Read data reflects the counter value before the cycle-t update (registered old value), with no bypass of same-cycle increments.
REQ-024 rd_idx >= N_CNT returns rd_data=0, rd_ovf=0 and rd_valid=1.
REQ-025 Back-to-back reads every cycle are supported at full throughput with no stall.

Reset
REQ-026 reset low asynchronously forces all counters, shadows, ovf, rd_data, rd_ovf and rd_valid to 0.
REQ-027 Reset released mid-operation resumes counting from 0 on the first edge after deassertion, with no spurious rd_valid.

Configuration
REQ-028 Macro PERF_SNAPSHOT_EN: when defined, snap=1 copies all N_CNT counters (pre-update values) into shadow registers, and reads return shadow values.
REQ-029 With PERF_SNAPSHOT_EN defined, snap and clr asserted in the same cycle give shadows the pre-clear values.
REQ-030 With PERF_SNAPSHOT_EN undefined, no shadow registers exist, snap is ignored, and reads return live counters.

Structure
REQ-031 A shared package perf_pkg holds the default widths (CNT_W_DEF=16, N_CNT_DEF=7) and the channel index constants (CNT_CTRL, CNT_ALU, CNT_INST, CNT_CYCLE, CNT_STALL, CNT_LOAD, CNT_STORE).
REQ-032 One sub-module, perf_counter_cell, implements a single counter with its inc/clr/freeze/saturate logic and sticky flag; the bank instantiates N_CNT of them with a generate loop.

Verification
REQ-033 Apply reset, then inc=7'h7F for 10 cycles, then read idx 3 -> rd_data=10, rd_valid=1 exactly one cycle after rd_en.
REQ-034 With CNT_W=8, SATURATE=0, pulse inc[0] 257 times -> rd_data=1 and ovf[0]=1; with SATURATE=1 -> rd_data=255 and ovf[0]=1.
REQ-035 Assert clr and inc=all-ones in the same cycle with counters at 5 -> all counters 0 and ovf=0 next cycle.
REQ-036 Hold freeze=1 for 4 cycles with inc active -> counter values unchanged; counting resumes when freeze drops.
REQ-037 With PERF_SNAPSHOT_EN defined, counters at 20, assert snap+clr, then read idx 0 -> rd_data=20 while the live counter is 0.
REQ-038 Assert reset low mid-count and during a pending read -> all outputs 0 immediately; rd_idx=7 with N_CNT=7 -> rd_data=0, rd_valid=1.
